sha256_msg_sched: RTL and testbench

//  Sequential SHA-256 message schedule generator. Accepts one 512-bit block
//  as 16 32-bit words, then emits W[0..63] one word per handshake. Uses the

---
 rtl/sha256_msg_sched.sv | 85 ++++++++
 tb/tb_sha256_msg_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads M[0..15], then emits W[0..NWORDS-1] one word per handshake; first word 1 clk after the 16th load.
// out_ready low freezes every output and all state; in_ready is low throughout emission, so inputs are never queued.
module sha256_msg_sched #(
    parameter int NWORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_idx,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [5:0] TLAST = 6'(NWORDS - 1);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] win [16];
    logic [3:0]  lcnt;
    logic [5:0]  t;
    logic [31:0] w_next;
    logic        in_hs;
    logic        out_hs;

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Outputs decode only registered state, so out_ready never reaches them combinationally.
    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == EMIT);
    assign out_word  = out_valid ? win[0] : 32'd0;
    assign out_idx   = t;
    assign out_last  = out_valid && (t == TLAST);
    assign busy      = out_valid || (lcnt != 4'd0);

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;
    assign w_next = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: if (in_hs && lcnt == 4'd15) state_d = EMIT;
            EMIT: if (out_hs && t == TLAST) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            lcnt    <= 4'd0;
            t       <= 6'd0;
            for (int k = 0; k < 16; k++) win[k] <= 32'd0;
        end else begin
            state_q <= state_d;
            if (in_hs) begin
                win[lcnt] <= in_word;
                lcnt      <= lcnt + 4'd1;   // wraps to 0 on the 16th word
                t         <= 6'd0;
            end
            if (out_hs) begin
                for (int k = 0; k < 15; k++) win[k] <= win[k+1];
                win[15] <= w_next;
                t       <= (t == TLAST) ? 6'd0 : t + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched: stimulus pushes expected W[t] from a reference
// schedule; a negedge monitor pops and compares on every output handshake.
module tb_sha256_msg_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        busy;

    sha256_msg_sched #(.NWORDS(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rdy_low = 0;
    int          overlap = 0;
    int          bp_mode = 0;   // 0: always ready, 1: random, 2: held low
    logic [31:0] mblk [16];
    logic [31:0] dut_w [64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic push_expected();
        logic [31:0] w [64];
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            if (i < 16) w[i] = mblk[i];
            else w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
            e.word = w[i];
            e.idx  = 6'(i);
            e.last = (i == 63);
            sb.push_back(e);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: handshake compare, stall stability, LOAD/EMIT exclusivity.
    logic        hold_vld = 1'b0;
    logic [39:0] held;
    always @(negedge clk) begin
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) check("stall_stable", {out_valid, out_word, out_idx, out_last}, held);
            hold_vld = 1'b0;
            if (!in_ready) rdy_low++;
            if (out_valid && in_ready) overlap++;
            if (out_valid) begin
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out", {out_idx, out_word}, 64'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("out_word", out_word, e.word);
                        check("out_idx", out_idx, e.idx);
                        check("out_last", out_last, e.last);
                        dut_w[out_idx] = out_word;
                    end
                end else begin
                    hold_vld = 1'b1;
                    held = {out_valid, out_word, out_idx, out_last};
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_word  = w;
        while (!in_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input bit gaps, output int c_first, output int r_first);
        c_first = 0;
        r_first = 0;
        push_expected();
        for (int i = 0; i < 16; i++) begin
            send_word(mblk[i]);
            if (i == 0) begin
                c_first = cyc;
                r_first = rdy_low;
                check("busy_partial_load", busy, 1);
            end
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_complete", (sb.size() == 0) && !out_valid, 1);
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) mblk[i] = 32'd0;
        mblk[0]  = 32'h61626380;
        mblk[15] = 32'h00000018;
    endtask

    initial begin
        int c0, c1, c2, r0, r1, r2, n;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_word", out_word, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // "abc" block with hand-derived words
        bp_mode = 0;
        load_abc();
        send_block(0, c0, r0);
        drain();
        check("abc_w0", dut_w[0], 32'h61626380);
        check("abc_w15", dut_w[15], 32'h00000018);
        check("abc_w16", dut_w[16], 32'h61626380);
        check("abc_w17", dut_w[17], 32'h000F0000);

        // All-ones block: modulo-2^32 wrap of the sum
        for (int i = 0; i < 16; i++) mblk[i] = 32'hFFFFFFFF;
        send_block(0, c0, r0);
        drain();

        // in_valid pulsed during emission must be ignored
        bp_mode = 1;
        for (int i = 0; i < 16; i++) mblk[i] = $urandom;
        send_block(1, c0, r0);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        in_valid = 1'b1;
        in_word  = 32'hDEADBEEF;
        repeat (5) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        drain();
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 1);
        for (int i = 0; i < 16; i++) mblk[i] = $urandom;
        send_block(1, c0, r0);
        drain();

        // Reset mid-emission at t=20
        for (int i = 0; i < 16; i++) mblk[i] = $urandom;
        send_block(0, c0, r0);
        n = 0;
        while (!(out_valid && out_idx == 6'd20) && n < 500) begin @(posedge clk); #1; n++; end
        check("reached_idx20", out_idx, 20);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_out_idx", out_idx, 0);
        rst = 1'b0;
        load_abc();
        send_block(1, c0, r0);
        drain();
        check("post_rst_w0", dut_w[0], 32'h61626380);

        // Back-to-back blocks, in_valid and out_ready held high
        bp_mode = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) mblk[i] = 32'h1000 + i;
        send_block(0, c0, r0);
        for (int i = 0; i < 16; i++) mblk[i] = 32'h2000 + i;
        send_block(0, c1, r1);
        for (int i = 0; i < 16; i++) mblk[i] = 32'h3000 + i;
        send_block(0, c2, r2);
        drain();
        check("b2b_clks_1", c1 - c0, 80);
        check("b2b_clks_2", c2 - c1, 80);
        check("b2b_ready_low", r1 - r0, 64);
        check("b2b_last_w0", dut_w[0], 32'h3000);

        // Random blocks under random backpressure and input gaps
        bp_mode = 1;
        for (int b = 0; b < 100; b++) begin
            for (int i = 0; i < 16; i++) mblk[i] = $urandom;
            send_block(1, c0, r0);
        end
        drain();
        check("load_emit_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
